// File: rtl/matrix_host_loader.sv
// rtl/matrix_host_loader.sv - host byte front end: loads operands A/B into RAM, runs the coprocessor, streams result C back
module matrix_host_loader #(
    parameter int WORD_W = 256,
    parameter int ADDR_W = 8,
    parameter int ADDR_A = 1,
    parameter int ADDR_B = 2,
    parameter int ADDR_C = 3,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [WORD_W-1:0] mem_q,
    output logic              mem_owner,
    output logic              cop_start,
    input  logic              cop_done,
    output logic              busy
);

    localparam int N     = WORD_W / 8;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [2:0] {
        LOAD_A, WRITE_A, LOAD_B, WRITE_B, WAIT_DONE, READ_C, READ_WAIT, UNLOAD
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  sreg;
    logic [WORD_W-1:0]  next_word;
    logic               in_fire;
    logic               out_fire;
    logic               last_cnt;

    // One shift register both assembles the incoming word (new bytes enter at the
    // top, so the first byte ends in [7:0]) and serialises the result low byte first.
    assign next_word = {in_data, sreg[WORD_W-1:8]};
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_cnt  = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD_A;
            cnt         <= '0;
            sreg        <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            cop_start   <= 1'b0;
            mem_owner   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        sreg <= next_word;
                        busy <= 1'b1;
                        cnt  <= cnt + CNT_W'(1);
                        if (last_cnt) begin
                            in_ready    <= 1'b0;
                            cnt         <= '0;
                            mem_wren    <= 1'b1;
                            mem_data    <= next_word;
                            if (state == LOAD_A) begin
                                mem_address <= ADDR_W'(ADDR_A);
                                state       <= WRITE_A;
                            end else begin
                                mem_address <= ADDR_W'(ADDR_B);
                                state       <= WRITE_B;
                            end
                        end
                    end
                end
                WRITE_A: begin
                    mem_wren <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= LOAD_B;
                end
                WRITE_B: begin
                    mem_wren  <= 1'b0;
                    cop_start <= 1'b1;
                    mem_owner <= 1'b0;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (cop_done) begin
                        cop_start   <= 1'b0;
                        mem_owner   <= 1'b1;
                        mem_address <= ADDR_W'(ADDR_C);
                        state       <= READ_C;
                    end
                end
                READ_C: begin
                    cnt   <= '0;
                    state <= READ_WAIT;
                end
                READ_WAIT: begin
                    // The cycle the address is presented counts toward RD_LAT.
                    if (cnt == CNT_W'(RD_LAT - 2)) begin
                        out_data  <= mem_q[7:0];
                        sreg      <= mem_q >> 8;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= UNLOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        out_data <= sreg[7:0];
                        sreg     <= sreg >> 8;
                        cnt      <= cnt + CNT_W'(1);
                        if (last_cnt) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            cnt       <= '0;
                            sreg      <= '0;
                            state     <= LOAD_A;
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_host_loader.sv
// tb/tb_matrix_host_loader.sv - scoreboard bench for matrix_host_loader with RAM/coprocessor model
module tb_matrix_host_loader;

    localparam int WORD_W = 256;
    localparam int ADDR_W = 8;
    localparam int ADDR_A = 1;
    localparam int ADDR_B = 2;
    localparam int ADDR_C = 3;
    localparam int RD_LAT = 2;
    localparam int N      = WORD_W / 8;
    localparam logic [WORD_W-1:0] PRE = {{(N-1){8'hFF}}, 8'h01};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_data;
    logic              mem_wren;
    logic [WORD_W-1:0] mem_q;
    logic              mem_owner;
    logic              cop_start;
    logic              cop_done = 1'b0;
    logic              busy;

    matrix_host_loader #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .ADDR_A(ADDR_A),
        .ADDR_B(ADDR_B), .ADDR_C(ADDR_C), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .mem_owner(mem_owner),
        .cop_start(cop_start), .cop_done(cop_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with one output register; the coprocessor stores A+B into C when done.
    logic [WORD_W-1:0] ram [0:255];
    logic [WORD_W-1:0] q1 = '0;
    bit compute = 1'b0;
    always @(posedge clk) begin
        if (mem_wren && mem_owner) ram[mem_address] <= mem_data;
        if (compute && cop_start && cop_done) ram[ADDR_C] <= ram[ADDR_A] + ram[ADDR_B];
        q1 <= (mem_address == ADDR_C && !compute) ? PRE : ram[mem_address];
    end
    assign mem_q = q1;

    int n_cmp = 0;
    int n_err = 0;
    logic [ADDR_W+WORD_W-1:0] exp_wr[$];
    logic [7:0]               exp_out[$];
    bit in_stall  = 1'b0;
    bit out_stall = 1'b0;

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and result bytes, checks timing and hold rules.
    initial begin
        bit prev_wr_b = 0, prev_ov = 0, prev_hold = 0, done_seen = 0;
        logic [7:0] prev_data = 0;
        int done_cyc = 0;
        logic [ADDR_W+WORD_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wr_b = 0; prev_ov = 0; prev_hold = 0; done_seen = 0;
            end else begin
                if (mem_wren) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write_addr", mem_address, '1);
                    end else begin
                        e = exp_wr.pop_front();
                        check("write_addr", mem_address, e[WORD_W +: ADDR_W]);
                        check("write_data", mem_data, e[WORD_W-1:0]);
                        check("write_owner", mem_owner, 1);
                    end
                end
                if (prev_wr_b) check("cop_start_after_write_b", cop_start, 1);
                prev_wr_b = mem_wren && (mem_address == ADDR_B);
                if (cop_start) check("owner_released", mem_owner, 0);
                if (cop_start && cop_done && !done_seen) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                end
                if (out_valid && !prev_ov && done_seen) begin
                    check("first_out_latency", cyc - done_cyc, 1 + RD_LAT);
                    done_seen = 0;
                end
                if (out_valid && prev_hold) check("out_hold", out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) check("unexpected_out_byte", out_data, '1);
                    else check("out_byte", out_data, exp_out.pop_front());
                end
                prev_ov   = out_valid;
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = out_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bit ok = 0;
        if (in_stall) while ($urandom_range(0, 1) == 1) begin
            in_valid = 0; @(posedge clk); #1;
        end
        in_valid = 1; in_data = b;
        while (!ok && t < 200) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; t++;
        end
        in_valid = 0;
        if (!ok) check("in_ready_timeout", ok, 1);
    endtask

    task automatic run_txn(input bit fixed, input int lat, input bit early, input bit spurious);
        logic [7:0] a [N];
        logic [7:0] b [N];
        logic [WORD_W-1:0] wa = '0, wb = '0, r;
        int t;
        for (int i = 0; i < N; i++) begin
            a[i] = fixed ? 8'(i) : 8'($urandom);
            b[i] = fixed ? 8'(N + i) : 8'($urandom);
            wa |= WORD_W'(a[i]) << (8 * i);
            wb |= WORD_W'(b[i]) << (8 * i);
        end
        r = compute ? wa + wb : PRE;
        exp_wr.push_back({ADDR_W'(ADDR_A), wa});
        exp_wr.push_back({ADDR_W'(ADDR_B), wb});
        for (int i = 0; i < N; i++) exp_out.push_back(r[8*i +: 8]);
        for (int i = 0; i < N; i++) begin
            send_byte(a[i]);
            if (spurious && i == 10) begin
                cop_done = 1; @(posedge clk); #1; cop_done = 0;
                @(negedge clk);
                check("spurious_in_ready", in_ready, 1);
                check("spurious_cop_start", cop_start, 0);
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (early && i == N - 1) cop_done = 1;
            send_byte(b[i]);
        end
        t = 0;
        while (!cop_start && t < 100) begin @(posedge clk); #1; t++; end
        check("cop_start_seen", cop_start, 1);
        check("busy_mid", busy, 1);
        if (!early) begin
            repeat (lat) @(posedge clk);
            #1; cop_done = 1;
            @(posedge clk); #1; cop_done = 0;
        end else begin
            t = 0;
            while (cop_start && t < 100) begin @(posedge clk); #1; t++; end
            cop_done = 0;
        end
        t = 0;
        while ((exp_out.size() != 0 || out_valid) && t < 2000) begin @(posedge clk); #1; t++; end
        @(negedge clk);
        check("bytes_remaining", exp_out.size(), 0);
        check("writes_remaining", exp_wr.size(), 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic mid_reset_txn();
        logic [WORD_W-1:0] wa = '0;
        logic [7:0] a [N];
        for (int i = 0; i < N; i++) begin
            a[i] = 8'($urandom);
            wa |= WORD_W'(a[i]) << (8 * i);
        end
        exp_wr.push_back({ADDR_W'(ADDR_A), wa});
        for (int i = 0; i < N; i++) send_byte(a[i]);
        for (int i = 0; i < 17; i++) send_byte(8'($urandom));
        rst = 1; @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("mid_reset_writes", exp_wr.size(), 0);
        check("mid_reset_wren", mem_wren, 0);
        check("mid_reset_owner", mem_owner, 1);
        check("mid_reset_cop_start", cop_start, 0);
        check("mid_reset_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 1; in_data = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_cop_start", cop_start, 0);
        check("rst_mem_owner", mem_owner, 1);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        @(posedge clk); #1;
        check("in_ready_after_rst", in_ready, 1);

        run_txn(1, 10, 0, 0);
        in_stall = 1; out_stall = 1;
        run_txn(1, 3, 0, 0);
        compute = 1; in_stall = 0; out_stall = 0;
        run_txn(0, 5, 0, 1);
        mid_reset_txn();
        run_txn(0, 0, 1, 0);
        in_stall = 1; out_stall = 1;
        for (int k = 0; k < 4; k++)
            run_txn(0, $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_host_loader.md
# matrix_host_loader

Host-side front end for the matrix coprocessor RAM. It accepts a byte stream of two 256-bit operand matrices and writes them into the single-port 256-bit RAM at operand addresses A and B. It then raises the coprocessor start, waits for completion, reads the result word from address C, and streams it back as bytes. It sits between the host byte link (HPS/UART bridge) and the RAM/coprocessor pair, and owns the RAM port whenever the coprocessor is not running.

## Interface
Parameters:
- WORD_W, 256, RAM word width; must be a multiple of 8
- ADDR_W, 8, RAM address width
- ADDR_A, 1, operand A word address
- ADDR_B, 2, operand B word address
- ADDR_C, 3, result word address
- RD_LAT, 2, cycles from address presented to valid mem_q

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
- out_valid  out  1  result byte valid
- out_data  out  8  result byte
- out_ready  in  1  host accepts result byte
- mem_address  out  ADDR_W  RAM address (valid while mem_owner=1)
- mem_data  out  WORD_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_q  in  WORD_W  RAM read data
- mem_owner  out  1  1 = loader drives RAM port, 0 = coprocessor does
- cop_start  out  1  level start to coprocessor
- cop_done  in  1  coprocessor finished (level or pulse)
- busy  out  1  transaction in progress

## Operation
- N = WORD_W/8 = 32 bytes per word. Byte k is placed in bits [8k+7:8k]; the first byte goes to [7:0].
- States: LOAD_A, WRITE_A, LOAD_B, WRITE_B, WAIT_DONE, READ_C, READ_WAIT, UNLOAD.
- LOAD_A / LOAD_B: in_ready=1. Each transfer stores a byte and increments a 5-bit byte counter. On the N-th transfer, go to WRITE_x and clear the counter.
- WRITE_A / WRITE_B: one cycle with mem_wren=1, mem_address=ADDR_A/ADDR_B, and mem_data=the assembled word. Then go to LOAD_B / WAIT_DONE.
- WAIT_DONE: mem_owner=0 and cop_start=1. cop_done is sampled only in this state. When cop_done=1, next cycle cop_start=0 and mem_owner=1, and go to READ_C.
- READ_C: mem_address=ADDR_C and mem_wren=0. Go to READ_WAIT.
- READ_WAIT: count RD_LAT-1 cycles. On the last count, capture mem_q into the output shift register and go to UNLOAD.
- UNLOAD: out_valid=1 and out_data=the current low byte. On out_ready, shift right 8 bits and increment the counter. After the N-th transfer, go to LOAD_A.
- in_ready=0 outside the LOAD states. The host stalls; bytes are never dropped.
- busy=1 from the first accepted byte of A until the last result byte is accepted.

## Timing
- Reset values (during the rst cycle and the first cycle after it): state LOAD_A, in_ready=0 during rst, then 1 the next cycle; out_valid=0, out_data=0, mem_wren=0, mem_address=0, mem_data=0, cop_start=0, mem_owner=1, busy=0, counters=0.
- All outputs are registered.
- Minimum load time is N cycles per word with in_valid held high. WRITE_x follows the N-th transfer by exactly 1 cycle.
- cop_start rises 1 cycle after WRITE_B.
- First out_valid occurs 1 + RD_LAT cycles after the cycle in which cop_done is sampled high.
- Minimum turnaround (A byte 0 to last result byte, zero coprocessor latency, no stalls): 2N + 2 + 1 + 1 + RD_LAT + N cycles.
- out_data and out_valid are held stable while out_ready=0.
- Reset mid-operation (any state) takes effect the same edge:
  - partial bytes are discarded;
  - cop_start drops and mem_owner returns to 1;
  - no RAM write occurs.
- cop_done while not in WAIT_DONE is ignored.
- A cop_done already high on entry to WAIT_DONE completes in 1 cycle.
- in_valid and out_ready may toggle every cycle; only the handshake cycles count.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → no byte accepted, all outputs at reset values; in_ready=1 the cycle after rst falls.
- Full load: stream bytes 0x00..0x1F for A and 0x20..0x3F for B, no stalls → mem_wren pulses exactly twice:
  - address 1, data with [7:0]=0x00 and [255:248]=0x1F;
  - address 2, data with [7:0]=0x20;
  - cop_start rises the next cycle.
- Completion and readback: model the RAM with RD_LAT=2 and address 3 preloaded with word 0xFF..FF01 in the low bytes; assert cop_done 10 cycles after start → out_valid appears 3 cycles later, the first byte is 0x01, 32 bytes are emitted low-first, then in_ready=1.
- Backpressure: random in_valid and out_ready (50%) → identical written words and output bytes to the no-stall run; out_data never changes while out_valid=1 and out_ready=0.
- Mid-operation reset: rst after 17 bytes of B, then a full new transaction → only one write to address 1 before the reset, and the new transaction's words are correct with no stale bytes.
- Spurious done: pulse cop_done during LOAD_A → ignored; state and counter are unchanged.
